// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search sequencer and its memory port mux.
package rc4_pkg;

  localparam int KEY_WIDTH_DEF  = 24;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_SHUF_GO,
    ST_SHUF_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_SHUF,
    OWN_DEC
  } owner_t;

endpackage

// File: rtl/s_mem_port_mux.sv
// Steers the single-port S-memory to the owning engine; purely combinational.
// With no owner the port is parked at zero so nothing is written.
import rc4_pkg::*;

module s_mem_port_mux #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  owner_t                owner,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_wdata,
  input  logic                  init_wren,
  input  logic [ADDR_WIDTH-1:0] shuf_addr,
  input  logic [DATA_WIDTH-1:0] shuf_wdata,
  input  logic                  shuf_wren,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [DATA_WIDTH-1:0] dec_wdata,
  input  logic                  dec_wren,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_wren
);

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_addr  = init_addr;
        s_wdata = init_wdata;
        s_wren  = init_wren;
      end
      OWN_SHUF: begin
        s_addr  = shuf_addr;
        s_wdata = shuf_wdata;
        s_wren  = shuf_wren;
      end
      OWN_DEC: begin
        s_addr  = dec_addr;
        s_wdata = dec_wdata;
        s_wren  = dec_wren;
      end
      default: begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequences init -> shuffle -> decode per candidate key, stepping the key on a bad
// decode until a good key is found or KEY_LAST has been tried; owns the S-memory grant.
import rc4_pkg::*;

module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST  = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = {2'b00, {(KEY_WIDTH-2){1'b1}}},
  parameter int                   ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                   DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  init_start,
  output logic                  shuf_start,
  output logic                  dec_start,
  input  logic                  init_done,
  input  logic                  shuf_done,
  input  logic                  dec_done,
  input  logic                  dec_bad_key,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_wdata,
  input  logic                  init_wren,
  input  logic [ADDR_WIDTH-1:0] shuf_addr,
  input  logic [DATA_WIDTH-1:0] shuf_wdata,
  input  logic                  shuf_wren,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [DATA_WIDTH-1:0] dec_wdata,
  input  logic                  dec_wren,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_wren,
  output logic [KEY_WIDTH-1:0]  secret_key,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted
);

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      key_q   <= KEY_FIRST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    owner_d    = OWN_NONE;
    init_start = 1'b0;
    shuf_start = 1'b0;
    dec_start  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (start) begin
          state_d = ST_INIT_GO;
          key_d   = KEY_FIRST;
        end
      end
      ST_INIT_GO: begin
        init_start = 1'b1;
        state_d    = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (init_done) state_d = ST_SHUF_GO;
      ST_SHUF_GO: begin
        shuf_start = 1'b1;
        state_d    = ST_SHUF_WAIT;
      end
      ST_SHUF_WAIT: if (shuf_done) state_d = ST_DEC_GO;
      ST_DEC_GO: begin
        dec_start = 1'b1;
        state_d   = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        if (dec_done) begin
          if (!dec_bad_key)        state_d = ST_FOUND;
          else if (key_q == KEY_LAST) state_d = ST_EXHAUSTED;
          else                     state_d = ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY: begin
        key_d   = key_q + KEY_WIDTH'(1);
        state_d = ST_INIT_GO;
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant is decided from the state being entered so it is already valid in X_GO.
    case (state_d)
      ST_INIT_GO, ST_INIT_WAIT: owner_d = OWN_INIT;
      ST_SHUF_GO, ST_SHUF_WAIT: owner_d = OWN_SHUF;
      ST_DEC_GO,  ST_DEC_WAIT:  owner_d = OWN_DEC;
      default:                  owner_d = OWN_NONE;
    endcase
  end

  assign secret_key = key_q;
  assign found      = (state_q == ST_FOUND);
  assign exhausted  = (state_q == ST_EXHAUSTED);
  assign busy       = (state_q != ST_IDLE) && !found && !exhausted;

  s_mem_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .owner     (owner_q),
    .init_addr (init_addr),
    .init_wdata(init_wdata),
    .init_wren (init_wren),
    .shuf_addr (shuf_addr),
    .shuf_wdata(shuf_wdata),
    .shuf_wren (shuf_wren),
    .dec_addr  (dec_addr),
    .dec_wdata (dec_wdata),
    .dec_wren  (dec_wren),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wren    (s_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Two sequencer instances (full key space and KEY_LAST=2) driven by stub engines.
module tb_rc4_key_search_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]  start, init_start, shuf_start, dec_start;
  logic [1:0]  init_done, shuf_done, dec_done, dec_bad_key, dec_force;
  logic [1:0]  s_wren, busy, found, exhausted;
  logic [23:0] secret_key [2];
  logic [7:0]  s_addr [2];
  logic [7:0]  s_wdata [2];
  logic [23:0] good_key;
  logic        init_wren, shuf_wren, dec_wren;

  localparam logic [7:0] IA = 8'h11, IDT = 8'hA1;
  localparam logic [7:0] SA = 8'h22, SDT = 8'hB2;
  localparam logic [7:0] DA = 8'h33, DDT = 8'hC3;

  int n_cmp  = 0;
  int n_fail = 0;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam logic [23:0] KL = (g == 1) ? 24'h000002 : 24'h3FFFFF;
      logic [3:0] icnt, scnt, dcnt;

      always @(posedge clock or posedge reset) begin
        if (reset) begin
          icnt <= 4'd0;
          scnt <= 4'd0;
          dcnt <= 4'd0;
        end else begin
          icnt <= init_start[g] ? 4'd5 : ((icnt != 4'd0) ? icnt - 4'd1 : 4'd0);
          scnt <= shuf_start[g] ? 4'd3 : ((scnt != 4'd0) ? scnt - 4'd1 : 4'd0);
          dcnt <= dec_start[g]  ? 4'd4 : ((dcnt != 4'd0) ? dcnt - 4'd1 : 4'd0);
        end
      end

      assign init_done[g]   = (icnt == 4'd1);
      assign shuf_done[g]   = (scnt == 4'd1);
      assign dec_done[g]    = (dcnt == 4'd1) | dec_force[g];
      assign dec_bad_key[g] = (secret_key[g] != good_key);

      rc4_key_search_ctrl #(
        .KEY_WIDTH(24), .KEY_FIRST(24'h000000), .KEY_LAST(KL),
        .ADDR_WIDTH(8), .DATA_WIDTH(8)
      ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start[g]),
        .init_start (init_start[g]),
        .shuf_start (shuf_start[g]),
        .dec_start  (dec_start[g]),
        .init_done  (init_done[g]),
        .shuf_done  (shuf_done[g]),
        .dec_done   (dec_done[g]),
        .dec_bad_key(dec_bad_key[g]),
        .init_addr  (IA),
        .init_wdata (IDT),
        .init_wren  (init_wren),
        .shuf_addr  (SA),
        .shuf_wdata (SDT),
        .shuf_wren  (shuf_wren),
        .dec_addr   (DA),
        .dec_wdata  (DDT),
        .dec_wren   (dec_wren),
        .s_addr     (s_addr[g]),
        .s_wdata    (s_wdata[g]),
        .s_wren     (s_wren[g]),
        .secret_key (secret_key[g]),
        .busy       (busy[g]),
        .found      (found[g]),
        .exhausted  (exhausted[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] klast(input int g);
    return (g == 1) ? 24'h000002 : 24'h3FFFFF;
  endfunction

  // Scoreboard: the model queues every key it expects decode to see, popped on dec_start.
  task automatic run_search(input int g, input logic [23:0] good, output int ndec);
    logic [23:0] q[$];
    logic [23:0] fin, exp;
    good_key = good;
    fin = (good <= klast(g)) ? good : klast(g);
    for (logic [23:0] k = 24'd0; k <= fin; k++) q.push_back(k);
    ndec = 0;
    @(negedge clock) start[g] = 1'b1;
    @(negedge clock) start[g] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (dec_start[g]) begin
        ndec++;
        exp = (q.size() != 0) ? q.pop_front() : 24'hBADBAD;
        chk("dec_key", {8'h0, secret_key[g]}, {8'h0, exp});
      end
      if (!busy[g]) break;
    end
    chk("search_timeout", {31'h0, busy[g]}, 32'h0);
    chk("queue_drained", q.size(), 32'h0);
  endtask

  typedef struct {
    int          g;
    logic [23:0] good;
    logic        exp_found;
    logic        exp_exh;
    logic [23:0] exp_key;
    int          exp_dec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  ndec, cnt;
    logic bad;

    start = '0; dec_force = '0; good_key = '0;
    init_wren = 1'b0; shuf_wren = 1'b0; dec_wren = 1'b0;

    vecs[0] = '{0, 24'h000003, 1'b1, 1'b0, 24'h000003, 4};
    vecs[1] = '{0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1};
    vecs[2] = '{1, 24'hFFFFFF, 1'b0, 1'b1, 24'h000002, 3};
    vecs[3] = '{1, 24'h000002, 1'b1, 1'b0, 24'h000002, 3};
    vecs[4] = '{1, 24'h000001, 1'b1, 1'b0, 24'h000001, 2};
    vecs[5] = '{0, 24'h000005, 1'b1, 1'b0, 24'h000005, 6};

    // Reset, then 20 idle cycles with no start.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    init_wren = 1'b1; shuf_wren = 1'b1; dec_wren = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if ((init_start | shuf_start | dec_start | s_wren | busy | found | exhausted) != 2'b00) bad = 1'b1;
      if (secret_key[0] != 24'h0 || secret_key[1] != 24'h0) bad = 1'b1;
    end
    chk("idle_outputs", {31'h0, bad}, 32'h0);
    chk("idle_key", {8'h0, secret_key[0]}, 32'h0);
    chk("idle_s_addr", {24'h0, s_addr[0]}, 32'h0);
    init_wren = 1'b0; shuf_wren = 1'b0; dec_wren = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_search(vecs[i].g, vecs[i].good, ndec);
      chk("vec_found", {31'h0, found[vecs[i].g]}, {31'h0, vecs[i].exp_found});
      chk("vec_exhausted", {31'h0, exhausted[vecs[i].g]}, {31'h0, vecs[i].exp_exh});
      chk("vec_key", {8'h0, secret_key[vecs[i].g]}, {8'h0, vecs[i].exp_key});
      chk("vec_dec_count", ndec, vecs[i].exp_dec);
    end

    // Grant: in SHUF_WAIT only shuf_wren may reach memory; NEXT_KEY parks the port.
    good_key = 24'h000001;
    @(negedge clock) start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    cnt = 0;
    while (!shuf_start[0] && cnt < 100) begin @(negedge clock); cnt++; end
    chk("grant_wait_shuf", {31'h0, shuf_start[0]}, 32'h1);
    @(negedge clock);
    init_wren = 1'b1; dec_wren = 1'b1; shuf_wren = 1'b0;
    #1 chk("grant_shuf_wren0", {31'h0, s_wren[0]}, 32'h0);
    chk("grant_shuf_addr", {24'h0, s_addr[0]}, {24'h0, SA});
    shuf_wren = 1'b1;
    #1 chk("grant_shuf_wren1", {31'h0, s_wren[0]}, 32'h1);
    chk("grant_shuf_wdata", {24'h0, s_wdata[0]}, {24'h0, SDT});
    cnt = 0;
    while (!dec_done[0] && cnt < 100) begin @(negedge clock); cnt++; end
    chk("grant_wait_done", {31'h0, dec_done[0]}, 32'h1);
    @(negedge clock);
    chk("nextkey_wren", {31'h0, s_wren[0]}, 32'h0);
    chk("nextkey_addr", {24'h0, s_addr[0]}, 32'h0);
    chk("nextkey_busy", {31'h0, busy[0]}, 32'h1);
    @(negedge clock);
    chk("nextkey_init_start", {31'h0, init_start[0]}, 32'h1);
    chk("nextkey_key", {8'h0, secret_key[0]}, 32'h1);
    init_wren = 1'b0; shuf_wren = 1'b0; dec_wren = 1'b0;
    cnt = 0;
    while (busy[0] && cnt < 200) begin @(negedge clock); cnt++; end
    chk("grant_found", {31'h0, found[0]}, 32'h1);

    // Spurious dec_done during INIT_WAIT must not advance the sequencer.
    good_key = 24'h000000;
    @(negedge clock) start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    chk("spur_init_start", {31'h0, init_start[0]}, 32'h1);
    @(negedge clock) dec_force[0] = 1'b1;
    @(negedge clock) dec_force[0] = 1'b0;
    cnt = 0; bad = 1'b0;
    while (!init_done[0] && cnt < 100) begin
      if (shuf_start[0] || dec_start[0] || !busy[0]) bad = 1'b1;
      @(negedge clock); cnt++;
    end
    chk("spur_no_advance", {31'h0, bad}, 32'h0);
    @(negedge clock);
    chk("spur_shuf_after_init", {31'h0, shuf_start[0]}, 32'h1);
    cnt = 0;
    while (busy[0] && cnt < 200) begin @(negedge clock); cnt++; end
    chk("spur_found", {31'h0, found[0]}, 32'h1);
    chk("spur_key", {8'h0, secret_key[0]}, 32'h0);

    // Asynchronous reset while decoding key 2 aborts at once.
    good_key = 24'h000003;
    @(negedge clock) start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    cnt = 0;
    while (!(dec_start[0] && secret_key[0] == 24'h2) && cnt < 300) begin @(negedge clock); cnt++; end
    chk("rst_reach_key2", {31'h0, dec_start[0]}, 32'h1);
    dec_wren = 1'b1;
    #1 chk("rst_pre_wren", {31'h0, s_wren[0]}, 32'h1);
    reset = 1'b1;
    #1 chk("rst_dec_start", {31'h0, dec_start[0]}, 32'h0);
    chk("rst_s_wren", {31'h0, s_wren[0]}, 32'h0);
    chk("rst_key", {8'h0, secret_key[0]}, 32'h0);
    chk("rst_busy", {31'h0, busy[0]}, 32'h0);
    @(negedge clock);
    reset = 1'b0; dec_wren = 1'b0;
    run_search(0, 24'h000001, ndec);
    chk("rst_restart_dec_count", ndec, 2);
    chk("rst_restart_found", {31'h0, found[0]}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
